// File: rtl/divider_pkg.sv
// Shared types and sizing helpers for the restoring divider slice.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Bit counter width: enough to count 2*dw restoring steps.
  function automatic int cnt_width(input int dw);
    return $clog2(2 * dw);
  endfunction

endpackage

// File: rtl/divider_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module divider_step #(
  parameter int DATAWIDTH = 4
) (
  input  logic [DATAWIDTH-1:0] rem_i,
  input  logic                 bit_i,
  input  logic [DATAWIDTH-1:0] divisor_i,
  output logic [DATAWIDTH-1:0] rem_o,
  output logic                 qbit_o
);

  logic [DATAWIDTH:0] shifted_s;

  // The incoming remainder is always below the divisor, so the difference fits in DATAWIDTH bits.
  always_comb begin
    shifted_s = {rem_i, bit_i};
    if (shifted_s >= {1'b0, divisor_i}) begin
      qbit_o = 1'b1;
      rem_o  = shifted_s[DATAWIDTH-1:0] - divisor_i;
    end else begin
      qbit_o = 1'b0;
      rem_o  = shifted_s[DATAWIDTH-1:0];
    end
  end

endmodule

// File: rtl/restoring_divider.sv
// Iterative restoring divider: 2*DATAWIDTH-bit dividend by DATAWIDTH-bit divisor, one quotient bit per clock.
module restoring_divider
  import divider_pkg::*;
#(
  parameter int DATAWIDTH   = 4,
  parameter int INSTANCE_ID = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_valid,
  output logic                   i_ready,
  input  logic [2*DATAWIDTH-1:0] dividend,
  input  logic [DATAWIDTH-1:0]   divisor,
  output logic                   o_valid,
  output logic [2*DATAWIDTH-1:0] quotient,
  output logic [DATAWIDTH-1:0]   remainder,
  output logic                   o_div_by_zero
);

  localparam int QW = 2 * DATAWIDTH;
  localparam int CW = cnt_width(DATAWIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(QW - 1);
  localparam int unused_instance_id = INSTANCE_ID;

  div_state_t           state_q, state_d;
  logic [QW-1:0]        dvd_q, dvd_d;
  logic [DATAWIDTH-1:0] dvs_q, dvs_d;
  logic [DATAWIDTH-1:0] rem_q, rem_d;
  logic [QW-1:0]        quot_q, quot_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [QW-1:0]        quotient_q, quotient_d;
  logic [DATAWIDTH-1:0] remainder_q, remainder_d;
  logic                 dbz_q, dbz_d;
  logic                 o_valid_q, o_valid_d;
  logic                 i_ready_q, i_ready_d;
  logic [DATAWIDTH-1:0] step_rem_s;
  logic                 step_qbit_s;

  divider_step #(.DATAWIDTH(DATAWIDTH)) u_step (
    .rem_i     (rem_q),
    .bit_i     (dvd_q[QW-1]),
    .divisor_i (dvs_q),
    .rem_o     (step_rem_s),
    .qbit_o    (step_qbit_s)
  );

  // Next-state logic for the handshake FSM and the shift/subtract datapath.
  always_comb begin
    state_d     = state_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    quot_d      = quot_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          dvd_d  = dividend;
          dvs_d  = divisor;
          rem_d  = '0;
          quot_d = '0;
          cnt_d  = '0;
          if (divisor == '0) begin
            state_d     = DONE;
            quotient_d  = '1;
            remainder_d = dividend[DATAWIDTH-1:0];
            dbz_d       = 1'b1;
          end else begin
            state_d = BUSY;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        dvd_d  = dvd_q << 1;
        rem_d  = step_rem_s;
        quot_d = {quot_q[QW-2:0], step_qbit_s};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          state_d     = DONE;
          cnt_d       = '0;
          quotient_d  = {quot_q[QW-2:0], step_qbit_s};
          remainder_d = step_rem_s;
          dbz_d       = 1'b0;
        end else begin
          state_d = BUSY;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    o_valid_d = (state_d == DONE);
    i_ready_d = (state_d == IDLE);
  end

  // State and output registers; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      quot_q      <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      o_valid_q   <= 1'b0;
      i_ready_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      quot_q      <= quot_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      o_valid_q   <= o_valid_d;
      i_ready_q   <= i_ready_d;
    end
  end

  assign i_ready       = i_ready_q;
  assign o_valid       = o_valid_q;
  assign quotient      = quotient_q;
  assign remainder     = remainder_q;
  assign o_div_by_zero = dbz_q;

endmodule
